hyperbus_ctrl: RTL and testbench
================================

HYPERBUS_CTRL -- requirements
Module: hyperbus_ctrl

Interface
REQ-001 Parameters: WIDTH, default 8, DQ bus width. TACC_COUNT, default 7, 1x initial latency in clk cycles. RESET_COUNT, default 4, phy_rstn low cycles. MAX_BURST, default 16, maximum beats per transaction. TIMEOUT_COUNT, default 32, maximum idle read cycles. CSN_IDLE, default 2, csn-high cycles between transactions.
REQ-002 Ports: clk in 1, sole clock; rst in 1, reset, synchronous active-high.
REQ-003 Request ports: req_i in 1; we_i in 1, 1=write; reg_space_i in 1; adr_i in 32; len_i in $clog2(MAX_BURST+1), beats; ack_o out 1.
REQ-004 Write data ports: wdat_i in 2*WIDTH; wmask_i in 2, 1=byte masked; wready_o out 1.
REQ-005 Read data ports: rdat_o out 2*WIDTH; rvalid_o out 1.
REQ-006 Status ports: busy_o out 1; error_o out 1; err_clr_i in 1.
REQ-007 PHY ports: phy_rstn out 1; phy_csn out 1; phy_ck_en out 1; phy_dq_o out 2*WIDTH; phy_dq_oe out 1; phy_dq_i in 2*WIDTH; phy_rwds_o out 2; phy_rwds_oe out 1; phy_rwds_i in 2.

Function
REQ-008 States: RESET, IDLE, CMD, LATENCY, WRITE, READ, CSHOLD, ERROR, one-hot encoded; an illegal encoding returns to RESET.
REQ-009 IDLE accepts a request when req_i=1; ack_o pulses high for that cycle only, and the next state is CMD; in any other state ack_o=0 and req_i is ignored.
REQ-010 The request fields are latched at acceptance. len_i=0 is treated as 1 beat, and len_i>MAX_BURST is clamped to MAX_BURST.
REQ-011 The CA word is ca[47]=~we_i, ca[46]=reg_space_i, ca[45]=1 (linear burst), ca[44:16]=adr_i[31:3], ca[15:3]=0, ca[2:0]=adr_i[2:0].
REQ-012 CMD lasts exactly 3 cycles, with phy_dq_o = ca[47:32], then ca[31:16], then ca[15:0]; phy_dq_oe=1, phy_ck_en=1, phy_csn=0, phy_rwds_oe=0.
REQ-013 phy_rwds_i is sampled in the first CMD cycle; any set bit selects 2x latency.
REQ-014 LATENCY lasts TACC_COUNT cycles (1x) or 2*TACC_COUNT cycles (2x), with phy_dq_oe=0 and phy_ck_en=1, then moves to WRITE if we_i else READ.
REQ-015 Register-space writes (reg_space_i=1, we_i=1) skip LATENCY, going from CMD directly to WRITE.
REQ-016 WRITE lasts exactly len cycles.
- wready_o=1 in each WRITE cycle.
- phy_dq_o=wdat_i, phy_rwds_o=wmask_i, phy_dq_oe=1, phy_rwds_oe=1.
- wdat_i and wmask_i must be valid whenever wready_o=1; there is no user backpressure.
- After the last beat the next state is CSHOLD.
REQ-017 READ: each cycle with phy_rwds_i!=0 is a beat; rdat_o<=phy_dq_i and rvalid_o<=1, registered (1-cycle latency). After len beats the next state is CSHOLD.
REQ-018 READ timeout: TIMEOUT_COUNT consecutive cycles without a beat moves the block to ERROR; the counter reloads on every beat.
REQ-019 CSHOLD holds phy_csn=1 and phy_ck_en=0 for CSN_IDLE cycles, then goes to IDLE.
REQ-020 ERROR holds phy_csn=1 and error_o=1 until err_clr_i=1, then goes to IDLE on the next cycle.
REQ-021 Output decode:
- phy_csn=0 only in CMD, LATENCY, WRITE and READ.
- busy_o=0 only in IDLE.
- phy_rstn=0 only in RESET.

Reset
REQ-022 rst=1 forces RESET on the next edge from any state, aborting any transaction; phy_csn=1 in the following cycle.
REQ-023 Reset values: phy_rstn=0, phy_csn=1, phy_ck_en=0, phy_dq_oe=0, phy_rwds_oe=0, phy_dq_o=0, phy_rwds_o=0, ack_o=0, wready_o=0, rvalid_o=0, rdat_o=0, busy_o=1, error_o=0.
REQ-024 RESET holds phy_rstn=0 for RESET_COUNT cycles after rst deasserts, then goes to IDLE.

Configuration
REQ-025 Macro HYPERBUS_FIXED_LATENCY_EN.
- Defined: latency is always 2*TACC_COUNT and the RWDS sample in CMD is ignored.
- Undefined: latency follows REQ-013.

Verification
REQ-026 Reset with RESET_COUNT=4 -> phy_rstn low for 4 cycles after rst falls, busy_o=0 on the next cycle.
REQ-027 Read of adr 0x0000_0013, len 4, RWDS=0 in CMD -> CA words 0xA000, 0x0002, 0x0003; 7 latency cycles; 4 rvalid_o pulses; then phy_csn high for 2 cycles.
REQ-028 Write of len 2 with wmask 2'b01 and RWDS=2'b11 in CMD -> 14 latency cycles; phy_rwds_o=01 on both beats; wready_o high for exactly 2 cycles.
REQ-029 Read where the PHY never strobes RWDS -> ERROR after 32 cycles; error_o=1; err_clr_i pulse returns the block to IDLE.
REQ-030 rst asserted mid-WRITE -> phy_csn=1 on the next cycle; all outputs take the values of REQ-023; req_i during RESET is not acknowledged.

Source files
------------

// File: rtl/hyperbus_ctrl.sv
// HyperBus master controller: CA phase, initial latency, burst read/write, timeout and reset sequencing.
// Optional macro HYPERBUS_FIXED_LATENCY_EN forces 2x initial latency and ignores RWDS during CMD.
module hyperbus_ctrl #(
   parameter int WIDTH         = 8,
   parameter int TACC_COUNT    = 7,
   parameter int RESET_COUNT   = 4,
   parameter int MAX_BURST     = 16,
   parameter int TIMEOUT_COUNT = 32,
   parameter int CSN_IDLE      = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_i,
   input  logic                           we_i,
   input  logic                           reg_space_i,
   input  logic [31:0]                    adr_i,
   input  logic [$clog2(MAX_BURST+1)-1:0] len_i,
   output logic                           ack_o,
   input  logic [2*WIDTH-1:0]             wdat_i,
   input  logic [1:0]                     wmask_i,
   output logic                           wready_o,
   output logic [2*WIDTH-1:0]             rdat_o,
   output logic                           rvalid_o,
   output logic                           busy_o,
   output logic                           error_o,
   input  logic                           err_clr_i,
   output logic                           phy_rstn,
   output logic                           phy_csn,
   output logic                           phy_ck_en,
   output logic [2*WIDTH-1:0]             phy_dq_o,
   output logic                           phy_dq_oe,
   input  logic [2*WIDTH-1:0]             phy_dq_i,
   output logic [1:0]                     phy_rwds_o,
   output logic                           phy_rwds_oe,
   input  logic [1:0]                     phy_rwds_i
);
   localparam int DW = 2*WIDTH;
   localparam int LW = $clog2(MAX_BURST+1);
   localparam logic [15:0] RST_LAST  = 16'(RESET_COUNT-1);
   localparam logic [15:0] HOLD_LAST = 16'(CSN_IDLE-1);
   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_COUNT-1);

   // Handshakes: a request is taken in the single cycle ack_o=1 (IDLE only) and its fields are
   // sampled then; a write beat is consumed every cycle wready_o=1 (no backpressure); a read beat
   // is presented for one cycle with rvalid_o=1 and must be taken by the user.
   typedef enum logic [7:0] {
      ST_RESET   = 8'h01,
      ST_IDLE    = 8'h02,
      ST_CMD     = 8'h04,
      ST_LATENCY = 8'h08,
      ST_WRITE   = 8'h10,
      ST_READ    = 8'h20,
      ST_CSHOLD  = 8'h40,
      ST_ERROR   = 8'h80
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d, tmo_q, tmo_d;
   logic [15:0]   len_last_q, lat_last;
   logic [47:0]   ca_q;
   logic          we_q, reg_q, lat2x_q, rvalid_q;
   logic [DW-1:0] rdat_q;
   logic [LW-1:0] len_eff;
   logic [15:0]   ca_word;
   logic          beat;

   assign beat     = |phy_rwds_i;
   assign lat_last = lat2x_q ? 16'(2*TACC_COUNT-1) : 16'(TACC_COUNT-1);
   assign rdat_o   = rdat_q;
   assign rvalid_o = rvalid_q;

   always_comb begin
      if (len_i == '0)                  len_eff = LW'(1);
      else if (len_i > LW'(MAX_BURST))  len_eff = LW'(MAX_BURST);
      else                              len_eff = len_i;
   end

   always_comb begin
      case (cnt_q)
         16'd0:   ca_word = ca_q[47:32];
         16'd1:   ca_word = ca_q[31:16];
         default: ca_word = ca_q[15:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RESET;
         cnt_q    <= '0;
         tmo_q    <= '0;
         rvalid_q <= 1'b0;
         rdat_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tmo_q    <= tmo_d;
         rvalid_q <= (state_q == ST_READ) && beat;
         if ((state_q == ST_READ) && beat) rdat_q <= phy_dq_i;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && req_i) begin
         we_q       <= we_i;
         reg_q      <= reg_space_i;
         len_last_q <= 16'(len_eff) - 16'd1;
         ca_q       <= {~we_i, reg_space_i, 1'b1, adr_i[31:3], 13'd0, adr_i[2:0]};
      end
      if (state_q == ST_CMD && cnt_q == 16'd0) begin
`ifdef HYPERBUS_FIXED_LATENCY_EN
         lat2x_q <= 1'b1;
`else
         lat2x_q <= beat;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tmo_d       = '0;
      ack_o       = 1'b0;
      wready_o    = 1'b0;
      busy_o      = 1'b1;
      error_o     = 1'b0;
      phy_rstn    = 1'b1;
      phy_csn     = 1'b1;
      phy_ck_en   = 1'b0;
      phy_dq_o    = '0;
      phy_dq_oe   = 1'b0;
      phy_rwds_o  = 2'b00;
      phy_rwds_oe = 1'b0;
      case (state_q)
         ST_RESET: begin
            phy_rstn = 1'b0;
            cnt_d    = cnt_q + 16'd1;
            if (cnt_q == RST_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         ST_IDLE: begin
            busy_o = 1'b0;
            cnt_d  = '0;
            if (req_i) begin
               ack_o   = 1'b1;
               state_d = ST_CMD;
            end
         end
         ST_CMD: begin
            phy_csn   = 1'b0;
            phy_ck_en = 1'b1;
            phy_dq_oe = 1'b1;
            phy_dq_o  = DW'(ca_word);
            cnt_d     = cnt_q + 16'd1;
            if (cnt_q == 16'd2) begin
               // register writes carry no initial latency
               state_d = (we_q && reg_q) ? ST_WRITE : ST_LATENCY;
               cnt_d   = '0;
            end
         end
         ST_LATENCY: begin
            phy_csn   = 1'b0;
            phy_ck_en = 1'b1;
            cnt_d     = cnt_q + 16'd1;
            if (cnt_q == lat_last) begin
               state_d = we_q ? ST_WRITE : ST_READ;
               cnt_d   = '0;
            end
         end
         ST_WRITE: begin
            phy_csn     = 1'b0;
            phy_ck_en   = 1'b1;
            wready_o    = 1'b1;
            phy_dq_o    = wdat_i;
            phy_dq_oe   = 1'b1;
            phy_rwds_o  = wmask_i;
            phy_rwds_oe = 1'b1;
            cnt_d       = cnt_q + 16'd1;
            if (cnt_q == len_last_q) begin
               state_d = ST_CSHOLD;
               cnt_d   = '0;
            end
         end
         ST_READ: begin
            phy_csn   = 1'b0;
            phy_ck_en = 1'b1;
            if (beat) begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == len_last_q) begin
                  state_d = ST_CSHOLD;
                  cnt_d   = '0;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = ST_ERROR;
               cnt_d   = '0;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         ST_CSHOLD: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == HOLD_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         ST_ERROR: begin
            error_o = 1'b1;
            cnt_d   = '0;
            if (err_clr_i) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_RESET;
            cnt_d   = '0;
         end
      endcase
   end
endmodule

// File: tb/tb_hyperbus_ctrl.sv
// Directed self-checking bench for hyperbus_ctrl: reset sequencing, CA words, latency, bursts,
// length clamping, read timeout with reload, error clear and reset abort.
module tb_hyperbus_ctrl;
   logic        clk, rst;
   logic        req_i, we_i, reg_space_i, ack_o;
   logic [31:0] adr_i;
   logic [4:0]  len_i;
   logic [15:0] wdat_i, rdat_o, phy_dq_o, phy_dq_i;
   logic [1:0]  wmask_i, phy_rwds_o, phy_rwds_i;
   logic        wready_o, rvalid_o, busy_o, error_o, err_clr_i;
   logic        phy_rstn, phy_csn, phy_ck_en, phy_dq_oe, phy_rwds_oe;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] exp_q[$];
   int r_first_v, r_nv, r_first_w, r_nw, r_nhold, r_end;

   hyperbus_ctrl dut (
      .clk(clk), .rst(rst),
      .req_i(req_i), .we_i(we_i), .reg_space_i(reg_space_i), .adr_i(adr_i), .len_i(len_i),
      .ack_o(ack_o), .wdat_i(wdat_i), .wmask_i(wmask_i), .wready_o(wready_o),
      .rdat_o(rdat_o), .rvalid_o(rvalid_o), .busy_o(busy_o), .error_o(error_o),
      .err_clr_i(err_clr_i), .phy_rstn(phy_rstn), .phy_csn(phy_csn), .phy_ck_en(phy_ck_en),
      .phy_dq_o(phy_dq_o), .phy_dq_oe(phy_dq_oe), .phy_dq_i(phy_dq_i),
      .phy_rwds_o(phy_rwds_o), .phy_rwds_oe(phy_rwds_oe), .phy_rwds_i(phy_rwds_i)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rstn"},   phy_rstn, 0);
      check({tag, "_csn"},    phy_csn, 1);
      check({tag, "_oes"},    {phy_ck_en, phy_dq_oe, phy_rwds_oe}, 0);
      check({tag, "_dq"},     phy_dq_o, 0);
      check({tag, "_rwds"},   phy_rwds_o, 0);
      check({tag, "_hs"},     {ack_o, wready_o, rvalid_o}, 0);
      check({tag, "_rdat"},   rdat_o, 0);
      check({tag, "_status"}, {busy_o, error_o}, 2'b10);
   endtask

   // issue a request from IDLE, check the three CA words, return in the first post-CMD cycle
   task automatic do_req(input logic we, input logic rs, input logic [31:0] adr, input logic [4:0] len,
                         input logic [1:0] rwds_cmd, input logic [15:0] e0, e1, e2);
      we_i = we; reg_space_i = rs; adr_i = adr; len_i = len; req_i = 1'b1;
      #1;
      check("ack", ack_o, 1);
      tick();
      req_i = 1'b0; phy_rwds_i = rwds_cmd;
      #1;
      check("ca0", phy_dq_o, e0);
      check("cmd_ack", ack_o, 0);
      check("cmd_csn", phy_csn, 0);
      check("cmd_oe", {phy_dq_oe, phy_ck_en, phy_rwds_oe}, 3'b110);
      tick();
      phy_rwds_i = 2'b00;
      check("ca1", phy_dq_o, e1);
      tick();
      check("ca2", phy_dq_o, e2);
      tick();
   endtask

   // mode 0: RWDS strobed every cycle; mode 1: strobes at idx 7 and 39 only; mode 2: never
   task automatic run_txn(input int mode);
      int idx;
      r_first_v = -1; r_nv = 0; r_first_w = -1; r_nw = 0; r_nhold = 0;
      idx = 0;
      while (busy_o && !error_o && idx < 200) begin
         phy_dq_i = 16'hD000 + 16'(idx);
         wdat_i   = 16'hB000 + 16'(idx);
         wmask_i  = 2'b01;
         case (mode)
            0:       phy_rwds_i = 2'b11;
            1:       phy_rwds_i = (idx == 7 || idx == 39) ? 2'b01 : 2'b00;
            default: phy_rwds_i = 2'b00;
         endcase
         #1;
         if (rvalid_o) begin
            if (r_first_v < 0) r_first_v = idx;
            r_nv++;
            if (exp_q.size() == 0) check("rd_extra", rvalid_o, 0);
            else check("rdat", rdat_o, exp_q.pop_front());
         end
         if (wready_o) begin
            if (r_first_w < 0) r_first_w = idx;
            r_nw++;
            check("wr_dq", phy_dq_o, wdat_i);
            check("wr_rwds", {phy_rwds_oe, phy_rwds_o}, 3'b101);
         end
         if (phy_csn && busy_o) r_nhold++;
         tick();
         idx++;
      end
      r_end = idx;
      phy_rwds_i = 2'b00;
      check("rd_left", exp_q.size(), 0);
   endtask

   initial begin
      rst = 1'b1; req_i = 0; we_i = 0; reg_space_i = 0; adr_i = '0; len_i = '0;
      wdat_i = '0; wmask_i = '0; err_clr_i = 0; phy_dq_i = '0; phy_rwds_i = '0;
      tick();
      tick();
      check_reset_outputs("por");

      // reset release: phy_rstn low for RESET_COUNT cycles, then IDLE
      begin
         int n;
         rst = 1'b0;
         n = 0;
         while (!phy_rstn && n < 20) begin n++; tick(); end
         check("rstn_low_cycles", n, 4);
         check("idle_busy", busy_o, 0);
      end

      // read 0x13 len 4, 1x latency
      for (int i = 7; i <= 10; i++) exp_q.push_back(16'hD000 + 16'(i));
      do_req(1'b0, 1'b0, 32'h0000_0013, 5'd4, 2'b00, 16'hA000, 16'h0002, 16'h0003);
      run_txn(0);
      check("rd_first_valid", r_first_v, 8);
      check("rd_beats", r_nv, 4);
      check("rd_hold", r_nhold, 2);
      check("rd_end", r_end, 13);

      // write 0x100 len 2, 2x latency
      do_req(1'b1, 1'b0, 32'h0000_0100, 5'd2, 2'b11, 16'h2000, 16'h0020, 16'h0000);
      run_txn(2);
      check("wr_first", r_first_w, 14);
      check("wr_beats", r_nw, 2);
      check("wr_hold", r_nhold, 2);
      check("wr_end", r_end, 18);

      // register write, len 0 -> one beat, no latency
      do_req(1'b1, 1'b1, 32'h0000_0008, 5'd0, 2'b00, 16'h6000, 16'h0001, 16'h0000);
      run_txn(2);
      check("rw_first", r_first_w, 0);
      check("rw_beats", r_nw, 1);
      check("rw_end", r_end, 3);

      // read len 20 clamps to 16
      for (int i = 7; i <= 22; i++) exp_q.push_back(16'hD000 + 16'(i));
      do_req(1'b0, 1'b0, 32'h0000_0000, 5'd20, 2'b00, 16'hA000, 16'h0000, 16'h0000);
      run_txn(0);
      check("clamp_beats", r_nv, 16);
      check("clamp_end", r_end, 25);

      // read with no strobes -> timeout into ERROR
      do_req(1'b0, 1'b0, 32'h0000_0040, 5'd1, 2'b00, 16'hA000, 16'h0008, 16'h0000);
      run_txn(2);
      check("tmo_end", r_end, 39);
      check("tmo_err", {error_o, busy_o, phy_csn}, 3'b111);
      err_clr_i = 1'b1;
      #1;
      check("tmo_err_hold", error_o, 1);
      tick();
      err_clr_i = 1'b0;
      check("clr_status", {busy_o, error_o}, 2'b00);

      // 31 idle cycles between beats stays clear of the timeout
      exp_q.push_back(16'hD007);
      exp_q.push_back(16'hD027);
      do_req(1'b0, 1'b0, 32'h0000_0007, 5'd2, 2'b00, 16'hA000, 16'h0000, 16'h0007);
      run_txn(1);
      check("reload_beats", r_nv, 2);
      check("reload_err", error_o, 0);
      check("reload_end", r_end, 42);

      // reset mid-write aborts; request held during RESET is not acknowledged
      do_req(1'b1, 1'b1, 32'h0000_0000, 5'd4, 2'b00, 16'h6000, 16'h0000, 16'h0000);
      tick();
      check("mid_wready", wready_o, 1);
      rst = 1'b1; req_i = 1'b1;
      tick();
      check_reset_outputs("abort");
      begin
         int n;
         rst = 1'b0;
         n = 0;
         while (!phy_rstn && n < 20) begin
            check("reset_ack", ack_o, 0);
            n++;
            tick();
         end
         check("abort_rstn_cycles", n, 4);
         check("post_reset_ack", ack_o, 1);
      end
      tick();
      req_i = 1'b0;
      run_txn(2);
      check("post_first_w", r_first_w, 3);
      check("post_beats", r_nw, 4);
      check("post_end", r_end, 9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
